// File: rtl/dram_req_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module   : dram_req_dispatcher_if
// Purpose  : Bundles the request-FIFO handshake, refresh handshake and DRAM
//            command bus used by dram_req_dispatcher.
// Ports    : fifo_dataout/fifo_empty/fifo_rd_en - request FIFO side
//            ref_req/ref_ack                     - refresh handshake
//            cmd/row_addr/col_addr               - DRAM command bus
//            busy/req_done                       - status
//            master modport: the dispatcher; slave modport: its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface dram_req_dispatcher_if #(
    parameter int ROW_W = 4,
    parameter int COL_W = 3
);
    localparam int REQ_W = 1 + ROW_W + COL_W;

    logic [REQ_W-1:0] fifo_dataout;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic             ref_req;
    logic             ref_ack;
    logic [2:0]       cmd;
    logic [ROW_W-1:0] row_addr;
    logic [COL_W-1:0] col_addr;
    logic             busy;
    logic             req_done;

    modport master (
        input  fifo_dataout, fifo_empty, ref_req,
        output fifo_rd_en, ref_ack, cmd, row_addr, col_addr, busy, req_done
    );

    modport slave (
        output fifo_dataout, fifo_empty, ref_req,
        input  fifo_rd_en, ref_ack, cmd, row_addr, col_addr, busy, req_done
    );
endinterface
`default_nettype wire

// File: rtl/dram_req_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : dram_req_dispatcher
// Purpose  : Pops {we,row,col} requests from a request FIFO and sequences
//            ACT -> RD/WR -> PRE on a single DRAM bank honouring tRCD, tRAS
//            and tRP; serves level refresh requests (REF, tRFC) from IDLE
//            with priority over pending requests.
// Ports    : clk, rst  - clock, synchronous active-high reset
//            bus       - dram_req_dispatcher_if.master (FIFO, refresh,
//                        command bus and status; all outputs registered)
// Revision : 1.0 - initial release
// ============================================================================
module dram_req_dispatcher #(
    parameter int ROW_W = 4,
    parameter int COL_W = 3,
    parameter int T_RCD = 2,
    parameter int T_RAS = 5,
    parameter int T_RP  = 2,
    parameter int T_RFC = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    dram_req_dispatcher_if.master bus
);
    localparam int c_MAX_A  = (T_RCD > T_RAS) ? T_RCD : T_RAS;
    localparam int c_MAX_B  = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int c_T_MAX  = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W  = $clog2(c_T_MAX + 1);

    // Each phase counter starts at 0 in the cycle its command is on the bus,
    // so an action due T cycles later is decided when the counter reads T-1.
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_RCD_LAST = c_CNT_W'(T_RCD - 1);
    localparam logic [c_CNT_W-1:0] c_RAS_LAST = c_CNT_W'(T_RAS - 1);
    localparam logic [c_CNT_W-1:0] c_RP_LAST  = c_CNT_W'(T_RP - 1);
    localparam logic [c_CNT_W-1:0] c_RFC_LAST = c_CNT_W'(T_RFC - 1);

    localparam logic [2:0] c_CMD_NOP = 3'b000;
    localparam logic [2:0] c_CMD_ACT = 3'b001;
    localparam logic [2:0] c_CMD_RD  = 3'b010;
    localparam logic [2:0] c_CMD_WR  = 3'b011;
    localparam logic [2:0] c_CMD_PRE = 3'b100;
    localparam logic [2:0] c_CMD_REF = 3'b101;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_POP      = 3'd1;
    localparam logic [2:0] c_ST_FETCH    = 3'd2;
    localparam logic [2:0] c_ST_ACT_WAIT = 3'd3;
    localparam logic [2:0] c_ST_PRE_WAIT = 3'd4;
    localparam logic [2:0] c_ST_REF_WAIT = 3'd5;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_cmd;
    logic               r_rd_en;
    logic               r_ref_ack;
    logic               r_req_done;
    logic               r_busy;
    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic               r_we;

    logic [2:0]         w_state_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [2:0]         w_cmd_next;
    logic               w_rd_en_next;
    logic               w_ref_ack_next;
    logic               w_req_done_next;
    logic               w_busy_next;
    logic [ROW_W-1:0]   w_row_next;
    logic [COL_W-1:0]   w_col_next;
    logic               w_we_next;

    // Next-state and next-output decode; every output is the registered
    // version of its w_*_next value so the bus never sees combinational paths.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_cmd_next      = c_CMD_NOP;
        w_rd_en_next    = 1'b0;
        w_ref_ack_next  = 1'b0;
        w_req_done_next = 1'b0;
        w_row_next      = r_row;
        w_col_next      = r_col;
        w_we_next       = r_we;

        case (r_state)
            c_ST_IDLE: begin
                w_cnt_next = '0;
                if (bus.ref_req) begin
                    // Refresh wins over a non-empty FIFO.
                    w_state_next   = c_ST_REF_WAIT;
                    w_cmd_next     = c_CMD_REF;
                    w_ref_ack_next = 1'b1;
                end else if (!bus.fifo_empty) begin
                    w_state_next = c_ST_POP;
                    w_rd_en_next = 1'b1;
                end
            end
            c_ST_POP: begin
                // FIFO presents the popped word during the following cycle.
                w_state_next = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                {w_we_next, w_row_next, w_col_next} = bus.fifo_dataout;
                w_cmd_next   = c_CMD_ACT;
                w_state_next = c_ST_ACT_WAIT;
                w_cnt_next   = '0;
            end
            c_ST_ACT_WAIT: begin
                w_cnt_next = r_cnt + c_CNT_ONE;
                if (r_cnt == c_RCD_LAST) begin
                    w_cmd_next = r_we ? c_CMD_WR : c_CMD_RD;
                end
                if (r_cnt == c_RAS_LAST) begin
                    w_cmd_next      = c_CMD_PRE;
                    w_req_done_next = 1'b1;
                    w_state_next    = c_ST_PRE_WAIT;
                    w_cnt_next      = '0;
                end
            end
            c_ST_PRE_WAIT: begin
                if (r_cnt == c_RP_LAST) begin
                    w_state_next = c_ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_ONE;
                end
            end
            c_ST_REF_WAIT: begin
                if (r_cnt == c_RFC_LAST) begin
                    w_state_next = c_ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase

        w_busy_next = (w_state_next != c_ST_IDLE);
    end

    // Reset drops any captured request: no RD/WR/PRE can follow it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_cmd      <= c_CMD_NOP;
            r_rd_en    <= 1'b0;
            r_ref_ack  <= 1'b0;
            r_req_done <= 1'b0;
            r_busy     <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_we       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_cmd      <= w_cmd_next;
            r_rd_en    <= w_rd_en_next;
            r_ref_ack  <= w_ref_ack_next;
            r_req_done <= w_req_done_next;
            r_busy     <= w_busy_next;
            r_row      <= w_row_next;
            r_col      <= w_col_next;
            r_we       <= w_we_next;
        end
    end

    assign bus.cmd        = r_cmd;
    assign bus.fifo_rd_en = r_rd_en;
    assign bus.ref_ack    = r_ref_ack;
    assign bus.req_done   = r_req_done;
    assign bus.busy       = r_busy;
    assign bus.row_addr   = r_row;
    assign bus.col_addr   = r_col;
endmodule
`default_nettype wire
